// File: rtl/exu_seq_ctrl_if.sv
// Handshake bundle for the execute-stage sequencer: the IDU op channel,
// the mul/div start/done channel and the WBU result channel.
interface exu_seq_ctrl_if #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
);
    // IDU -> EXU op channel
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      in_op_class;
    logic [RD_W-1:0] in_rd;
    logic            in_wen;

    // EXU <-> iterative mul/div unit
    logic            md_start;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    // EXU -> WBU result channel
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [RD_W-1:0] out_rd;
    logic            out_wen;

    // Sequencer view
    modport slave (
        input  in_valid, in_op_class, in_rd, in_wen,
        input  md_done, md_result,
        input  out_ready,
        output in_ready, md_start,
        output out_valid, out_result, out_rd, out_wen
    );

    // Environment view (IDU, mul/div unit and WBU together)
    modport master (
        output in_valid, in_op_class, in_rd, in_wen,
        output md_done, md_result,
        output out_ready,
        input  in_ready, md_start,
        input  out_valid, out_result, out_rd, out_wen
    );
endinterface

// File: rtl/exu_seq_ctrl.sv
// Execute-stage sequencing controller. Accepts one op at a time from the
// IDU, runs it on the single-cycle ALU or the iterative mul/div unit, holds
// the result for the WBU, and turns ebreak into a halt that only reset clears.
module exu_seq_ctrl #(
    parameter int XLEN       = 32,
    parameter int RD_W       = 5,
    parameter int MD_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    exu_seq_ctrl_if.slave   bus,
    output logic            op_latch_en,
    input  logic [XLEN-1:0] alu_result,
    output logic            md_err,
    output logic            halt
);

    localparam int CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MDWAIT,
        ST_OUT,
        ST_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              wen_q, wen_d;
    logic              md_err_q, md_err_d;
    logic              in_ready;
    logic              accept;

    // Next-state and handshake logic; the wait counter doubles as the
    // "first MDWAIT cycle" marker because it is zero exactly on entry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rd_d     = rd_q;
        wen_d    = wen_q;
        md_err_d = md_err_q;

        in_ready = (state_q == ST_IDLE) || ((state_q == ST_OUT) && bus.out_ready);
        accept   = bus.in_valid && in_ready;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_EXEC: begin
                result_d = alu_result;
                state_d  = ST_OUT;
            end
            ST_MDWAIT: begin
                if (bus.md_done) begin
                    result_d = bus.md_result;
                    cnt_d    = '0;
                    state_d  = ST_OUT;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = '0;
                    wen_d    = 1'b0;
                    md_err_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_OUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (accept) begin
            rd_d  = bus.in_rd;
            wen_d = bus.in_wen;
            case (bus.in_op_class)
                2'd1:    state_d = ST_MDWAIT;
                2'd2:    state_d = ST_HALT;
                default: state_d = ST_EXEC;
            endcase
        end
    end

    // State, counter and held-result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
            wen_q    <= 1'b0;
            md_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            wen_q    <= wen_d;
            md_err_q <= md_err_d;
        end
    end

    assign op_latch_en    = accept;
    assign bus.in_ready   = in_ready;
    assign bus.md_start   = (state_q == ST_MDWAIT) && (cnt_q == '0);
    assign bus.out_valid  = (state_q == ST_OUT);
    assign bus.out_result = result_q;
    assign bus.out_rd     = rd_q;
    assign bus.out_wen    = wen_q;
    assign md_err         = md_err_q;
    assign halt           = (state_q == ST_HALT);

endmodule

// File: tb/tb_exu_seq_ctrl.sv
// Testbench for exu_seq_ctrl: directed vector table, hand-written
// multi-cycle sequences, and random traffic against a transaction model.
module tb_exu_seq_ctrl;

    localparam int MD_TO = 8;

    logic        clk;
    logic        rst_n;
    logic        op_latch_en;
    logic [31:0] alu_result;
    logic        md_err;
    logic        halt;

    int total;
    int bad;

    exu_seq_ctrl_if #(.XLEN(32), .RD_W(5)) bus ();

    exu_seq_ctrl #(.XLEN(32), .RD_W(5), .MD_TIMEOUT(MD_TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .op_latch_en(op_latch_en),
        .alu_result (alu_result),
        .md_err     (md_err),
        .halt       (halt)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [1:0]  cls;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] alu;
        logic        ordy;
        logic        mdd;
        logic [31:0] mdr;
        logic        e_rdy;
        logic        e_latch;
        logic        e_start;
        logic        e_ov;
        logic [31:0] e_res;
        logic [4:0]  e_rd;
        logic        e_wen;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        wen;
    } wb_t;

    vec_t vecs[$];
    wb_t  exp_q[$];

    function automatic vec_t mkVec(logic iv, logic [1:0] cls, logic [4:0] rd, logic wen,
                                   logic [31:0] alu, logic ordy, logic mdd, logic [31:0] mdr,
                                   logic e_rdy, logic e_latch, logic e_start, logic e_ov,
                                   logic [31:0] e_res, logic [4:0] e_rd, logic e_wen);
        vec_t v;
        v.iv = iv; v.cls = cls; v.rd = rd; v.wen = wen; v.alu = alu;
        v.ordy = ordy; v.mdd = mdd; v.mdr = mdr;
        v.e_rdy = e_rdy; v.e_latch = e_latch; v.e_start = e_start; v.e_ov = e_ov;
        v.e_res = e_res; v.e_rd = e_rd; v.e_wen = e_wen;
        return v;
    endfunction

    task automatic applyStimulus(input logic iv, input logic [1:0] cls, input logic [4:0] rd,
                                 input logic wen, input logic [31:0] alu, input logic ordy,
                                 input logic mdd, input logic [31:0] mdr);
        bus.in_valid    = iv;
        bus.in_op_class = cls;
        bus.in_rd       = rd;
        bus.in_wen      = wen;
        alu_result      = alu;
        bus.out_ready   = ordy;
        bus.md_done     = mdd;
        bus.md_result   = mdr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sampleCycle();
        @(negedge clk);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 2'd0, 5'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Random-phase model state
    int          cyc;
    int          md_due;
    int          md_start_due;
    int          alu_due;
    logic [31:0] alu_hold;
    logic [31:0] md_val;
    bit          model_err;
    bit          acc_prev;

    task automatic randomCycle(input bit allow_issue);
        logic        iv;
        logic [1:0]  cls;
        logic [4:0]  rd;
        logic        wen;
        logic        ordy;
        logic        acc;
        int          r;
        int          lat;
        wb_t         w;
        wb_t         e;

        nextCycle();
        r    = $urandom_range(0, 2);
        cls  = (r == 2) ? 2'd3 : 2'(r);
        iv   = allow_issue ? 1'($urandom_range(0, 1)) : 1'b0;
        rd   = 5'($urandom);
        wen  = 1'($urandom);
        ordy = allow_issue ? ($urandom_range(0, 3) != 0) : 1'b1;
        applyStimulus(iv, cls, rd, wen,
                      (cyc == alu_due) ? alu_hold : $urandom,
                      ordy, (cyc == md_due),
                      (cyc == md_due) ? md_val : $urandom);
        sampleCycle();

        acc = iv && bus.in_ready;
        checkOutput("rnd_latch_en", 32'(op_latch_en), 32'(acc));
        checkOutput("rnd_md_start", 32'(bus.md_start), 32'(cyc == md_start_due));
        checkOutput("rnd_halt", 32'(halt), 32'd0);
        if (acc_prev) begin
            checkOutput("rnd_busy_ready", 32'(bus.in_ready), 32'd0);
        end

        if (bus.out_valid && ordy) begin
            checkOutput("rnd_wb_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("rnd_result", bus.out_result, e.res);
                checkOutput("rnd_rd", 32'(bus.out_rd), 32'(e.rd));
                checkOutput("rnd_wen", 32'(bus.out_wen), 32'(e.wen));
                checkOutput("rnd_md_err", 32'(md_err), 32'(model_err));
            end
        end

        if (acc) begin
            if (cls == 2'd1) begin
                lat          = $urandom_range(0, 11);
                md_start_due = cyc + 1;
                if (lat < MD_TO) begin
                    md_val = $urandom;
                    md_due = cyc + 1 + lat;
                    w.res  = md_val;
                    w.rd   = rd;
                    w.wen  = wen;
                end else begin
                    md_due    = -1;
                    w.res     = 32'd0;
                    w.rd      = rd;
                    w.wen     = 1'b0;
                    model_err = 1'b1;
                end
            end else begin
                alu_hold = $urandom;
                alu_due  = cyc + 1;
                w.res    = alu_hold;
                w.rd     = rd;
                w.wen    = wen;
            end
            exp_q.push_back(w);
        end
        acc_prev = acc;
        cyc++;
    endtask

    initial begin
        int waits;
        int starts;
        bit seen;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;

        // Directed per-cycle table: ALU, backpressure, back-to-back, mul/div
        vecs.push_back(mkVec(1, 0, 5, 1, 32'h0,        0, 0, 32'h0,   1, 1, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h12,       0, 0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,   1, 0, 0, 1, 32'h12,       5, 1));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 1, 32'hBAD, 1, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(1, 0, 3, 0, 32'h0,        0, 0, 32'h0,   1, 1, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h55,       0, 0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(1, 0, 9, 1, 32'h0,        0, 0, 32'h0,   0, 0, 0, 1, 32'h55,       3, 0));
        vecs.push_back(mkVec(1, 0, 9, 1, 32'h0,        0, 0, 32'h0,   0, 0, 0, 1, 32'h55,       3, 0));
        vecs.push_back(mkVec(1, 0, 9, 1, 32'h0,        0, 0, 32'h0,   0, 0, 0, 1, 32'h55,       3, 0));
        vecs.push_back(mkVec(1, 0, 9, 1, 32'h0,        1, 0, 32'h0,   1, 1, 0, 1, 32'h55,       3, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 1, 32'hDEADBEEF, 9, 1));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,   1, 0, 0, 1, 32'hDEADBEEF, 9, 1));
        vecs.push_back(mkVec(1, 1, 7, 1, 32'h0,        0, 0, 32'h0,   1, 1, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 1, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 1, 32'h190, 0, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,   1, 0, 0, 1, 32'h190,      7, 1));
        vecs.push_back(mkVec(1, 1, 2, 1, 32'h0,        0, 0, 32'h0,   1, 1, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        0, 1, 32'hABC, 0, 0, 1, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,   1, 0, 0, 1, 32'hABC,      2, 1));
        vecs.push_back(mkVec(1, 3, 4, 1, 32'h0,        0, 0, 32'h0,   1, 1, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h77,       0, 0, 32'h0,   0, 0, 0, 0, 32'h0,        0, 0));
        vecs.push_back(mkVec(0, 0, 0, 0, 32'h0,        1, 0, 32'h0,   1, 0, 0, 1, 32'h77,       4, 1));

        doReset();
        sampleCycle();
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_result", bus.out_result, 32'd0);
        checkOutput("rst_out_rd", 32'(bus.out_rd), 32'd0);
        checkOutput("rst_out_wen", 32'(bus.out_wen), 32'd0);
        checkOutput("rst_md_err", 32'(md_err), 32'd0);
        checkOutput("rst_halt", 32'(halt), 32'd0);
        checkOutput("rst_md_start", 32'(bus.md_start), 32'd0);

        $display("[TB] directed vector table, %0d rows", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            nextCycle();
            applyStimulus(vecs[i].iv, vecs[i].cls, vecs[i].rd, vecs[i].wen,
                          vecs[i].alu, vecs[i].ordy, vecs[i].mdd, vecs[i].mdr);
            sampleCycle();
            checkOutput($sformatf("vec%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_rdy));
            checkOutput($sformatf("vec%0d_latch", i), 32'(op_latch_en), 32'(vecs[i].e_latch));
            checkOutput($sformatf("vec%0d_md_start", i), 32'(bus.md_start), 32'(vecs[i].e_start));
            checkOutput($sformatf("vec%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
            if (vecs[i].e_ov) begin
                checkOutput($sformatf("vec%0d_result", i), bus.out_result, vecs[i].e_res);
                checkOutput($sformatf("vec%0d_rd", i), 32'(bus.out_rd), 32'(vecs[i].e_rd));
                checkOutput($sformatf("vec%0d_wen", i), 32'(bus.out_wen), 32'(vecs[i].e_wen));
            end
        end
        checkOutput("table_md_err", 32'(md_err), 32'd0);

        // Mul/div timeout: md_done never arrives
        $display("[TB] mul/div timeout sequence");
        nextCycle();
        applyStimulus(1, 2'd1, 5'd6, 1, 32'h0, 0, 0, 32'h0);
        sampleCycle();
        checkOutput("to_latch", 32'(op_latch_en), 32'd1);
        waits  = 0;
        starts = 0;
        seen   = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            nextCycle();
            applyStimulus(0, 2'd0, 5'd0, 0, 32'h0, 0, 0, 32'h0);
            sampleCycle();
            if (bus.md_start) starts++;
            if (bus.out_valid) seen = 1;
            else waits++;
        end
        checkOutput("to_wait_cycles", 32'(waits), 32'(MD_TO));
        checkOutput("to_start_pulses", 32'(starts), 32'd1);
        checkOutput("to_result", bus.out_result, 32'd0);
        checkOutput("to_wen", 32'(bus.out_wen), 32'd0);
        checkOutput("to_rd", 32'(bus.out_rd), 32'd6);
        checkOutput("to_md_err", 32'(md_err), 32'd1);
        nextCycle();
        applyStimulus(1, 2'd0, 5'd1, 1, 32'h0, 1, 0, 32'h0);
        sampleCycle();
        checkOutput("to_b2b_latch", 32'(op_latch_en), 32'd1);
        nextCycle();
        applyStimulus(0, 2'd0, 5'd0, 0, 32'h11, 0, 0, 32'h0);
        nextCycle();
        applyStimulus(0, 2'd0, 5'd0, 0, 32'h0, 1, 0, 32'h0);
        sampleCycle();
        checkOutput("to_next_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("to_next_result", bus.out_result, 32'h11);
        checkOutput("to_next_wen", 32'(bus.out_wen), 32'd1);
        checkOutput("to_sticky_err", 32'(md_err), 32'd1);

        // Async reset in the first MDWAIT cycle
        $display("[TB] async reset during MDWAIT");
        nextCycle();
        applyStimulus(1, 2'd1, 5'd3, 1, 32'h0, 0, 0, 32'h0);
        nextCycle();
        applyStimulus(0, 2'd0, 5'd0, 0, 32'h0, 0, 0, 32'h0);
        sampleCycle();
        checkOutput("ar_md_start_before", 32'(bus.md_start), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_md_start", 32'(bus.md_start), 32'd0);
        checkOutput("ar_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("ar_halt", 32'(halt), 32'd0);
        checkOutput("ar_md_err", 32'(md_err), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        nextCycle();
        applyStimulus(1, 2'd0, 5'd8, 1, 32'h0, 0, 0, 32'h0);
        sampleCycle();
        checkOutput("ar_alu_latch", 32'(op_latch_en), 32'd1);
        nextCycle();
        applyStimulus(0, 2'd0, 5'd0, 0, 32'h99, 0, 0, 32'h0);
        sampleCycle();
        checkOutput("ar_alu_exec_valid", 32'(bus.out_valid), 32'd0);
        nextCycle();
        applyStimulus(0, 2'd0, 5'd0, 0, 32'h0, 1, 0, 32'h0);
        sampleCycle();
        checkOutput("ar_alu_valid", 32'(bus.out_valid), 32'd1);
        checkOutput("ar_alu_result", bus.out_result, 32'h99);
        checkOutput("ar_alu_rd", 32'(bus.out_rd), 32'd8);

        // Ebreak: sticky halt, everything else ignored until reset
        $display("[TB] ebreak sequence");
        nextCycle();
        applyStimulus(1, 2'd2, 5'd0, 0, 32'h0, 1, 0, 32'h0);
        sampleCycle();
        checkOutput("eb_latch", 32'(op_latch_en), 32'd1);
        for (int i = 0; i < 20; i++) begin
            nextCycle();
            applyStimulus(1, 2'($urandom), 5'($urandom), 1, $urandom, 1, 1'($urandom), $urandom);
            sampleCycle();
            checkOutput("eb_halt", 32'(halt), 32'd1);
            checkOutput("eb_in_ready", 32'(bus.in_ready), 32'd0);
            checkOutput("eb_out_valid", 32'(bus.out_valid), 32'd0);
            checkOutput("eb_md_start", 32'(bus.md_start), 32'd0);
            checkOutput("eb_latch_off", 32'(op_latch_en), 32'd0);
        end
        nextCycle();
        applyStimulus(0, 2'd0, 5'd0, 0, 32'h0, 0, 0, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("eb_reset_halt", 32'(halt), 32'd0);
        checkOutput("eb_reset_ready", 32'(bus.in_ready), 32'd1);
        doReset();

        // Random traffic against the transaction model
        $display("[TB] random traffic");
        cyc          = 0;
        md_due       = -1;
        md_start_due = -1;
        alu_due      = -1;
        alu_hold     = 32'd0;
        md_val       = 32'd0;
        model_err    = 1'b0;
        acc_prev     = 1'b0;
        for (int i = 0; i < 800; i++) begin
            randomCycle(1'b1);
        end
        for (int i = 0; i < 40; i++) begin
            randomCycle(1'b0);
        end
        checkOutput("rnd_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
